// File: rtl/arbitro_ula_if.sv
// -----------------------------------------------------------------------------
// arbitro_ula_if
// Bundles every non-clock signal of the ALU arbiter:
//   requester side : req0/1, op0/1, a0/1, b0/1 (in)  -> gnt0/1, done0/1,
//                    resultado, zero, ocupado (out)
//   ALU side       : ctrl_ula, num2, num1 (out to ALU),
//                    resultado_ula, zero_ula (in from ALU)
// modport slave  : the arbiter itself.
// modport master : the surroundings (requesters plus the combinational ALU).
// -----------------------------------------------------------------------------
interface arbitro_ula_if #(
    parameter int LARGURA = 8
);
    // requester 0
    logic               req0;
    logic               op0;
    logic [LARGURA-1:0] a0;
    logic [LARGURA-1:0] b0;
    logic               gnt0;
    logic               done0;
    // requester 1
    logic               req1;
    logic               op1;
    logic [LARGURA-1:0] a1;
    logic [LARGURA-1:0] b1;
    logic               gnt1;
    logic               done1;
    // shared response
    logic [LARGURA-1:0] resultado;
    logic               zero;
    logic               ocupado;
    // ALU connection
    logic               ctrl_ula;
    logic [LARGURA-1:0] num2;
    logic [LARGURA-1:0] num1;
    logic [LARGURA-1:0] resultado_ula;
    logic               zero_ula;

    modport slave (
        input  req0, op0, a0, b0,
        input  req1, op1, a1, b1,
        output gnt0, done0, gnt1, done1,
        output resultado, zero, ocupado,
        output ctrl_ula, num2, num1,
        input  resultado_ula, zero_ula
    );

    modport master (
        output req0, op0, a0, b0,
        output req1, op1, a1, b1,
        input  gnt0, done0, gnt1, done1,
        input  resultado, zero, ocupado,
        input  ctrl_ula, num2, num1,
        output resultado_ula, zero_ula
    );
endinterface

// File: rtl/arbitro_ula.sv
// -----------------------------------------------------------------------------
// arbitro_ula
// Round-robin arbiter/sequencer sharing one combinational add/subtract ALU
// between two requesters. A winning request is latched onto the ALU inputs,
// the ALU result and zero flag are registered one cycle later, and a one-cycle
// done pulse returns them to the requester that was served.
//
// Ports:
//   clock  : rising-edge system clock
//   resetn : asynchronous, active-low reset
//   bus    : arbitro_ula_if.slave (requests, grants, done pulses, shared
//            result/zero, ocupado, and the ALU control/operand/result wires)
//
// LARGURA must equal the width the interface instance was built with.
// -----------------------------------------------------------------------------
module arbitro_ula #(
    parameter int LARGURA = 8
) (
    input  logic              clock,
    input  logic              resetn,
    arbitro_ula_if.slave      bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t            estado;
    logic               ultimo;      // requester served last (1 after reset)
    logic               armado0;     // requester may be served again
    logic               armado1;
    logic               gnt0_r, gnt1_r;
    logic               done0_r, done1_r;
    logic               ocupado_r;
    logic               ctrl_r;
    logic [LARGURA-1:0] num2_r, num1_r;
    logic [LARGURA-1:0] resultado_r;
    logic               zero_r;

    logic               elegivel0, elegivel1;
    logic               concede;
    logic               vence1;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        elegivel0 = 1'b0;
        elegivel1 = 1'b0;
        concede   = 1'b0;
        vence1    = 1'b0;
        elegivel0 = bus.req0 & armado0;
        elegivel1 = bus.req1 & armado1;
        concede   = elegivel0 | elegivel1;
        // On a tie the requester not served last wins; ultimo = 1 favours 0.
        vence1    = elegivel1 & (~elegivel0 | ~ultimo);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado      <= OCIOSO;
            ultimo      <= 1'b1;
            armado0     <= 1'b1;
            armado1     <= 1'b1;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            ocupado_r   <= 1'b0;
            ctrl_r      <= 1'b0;
            num2_r      <= '0;
            num1_r      <= '0;
            resultado_r <= '0;
            zero_r      <= 1'b0;
        end else begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;

            // Dropping req re-arms a requester; the clear in RESPONDE below
            // comes later in the block and therefore wins.
            if (!bus.req0) armado0 <= 1'b1;
            if (!bus.req1) armado1 <= 1'b1;

            case (estado)
                OCIOSO: begin
                    if (concede) begin
                        estado    <= EXECUTA;
                        ocupado_r <= 1'b1;
                        gnt0_r    <= ~vence1;
                        gnt1_r    <= vence1;
                        ultimo    <= vence1;
                        ctrl_r    <= vence1 ? bus.op1 : bus.op0;
                        num2_r    <= vence1 ? bus.a1  : bus.a0;
                        num1_r    <= vence1 ? bus.b1  : bus.b0;
                    end
                end
                EXECUTA: begin
                    resultado_r <= bus.resultado_ula;
                    zero_r      <= bus.zero_ula;
                    estado      <= RESPONDE;
                end
                RESPONDE: begin
                    done0_r   <= gnt0_r;
                    done1_r   <= gnt1_r;
                    if (gnt0_r) armado0 <= 1'b0;
                    if (gnt1_r) armado1 <= 1'b0;
                    gnt0_r    <= 1'b0;
                    gnt1_r    <= 1'b0;
                    ocupado_r <= 1'b0;
                    estado    <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.done0     = done0_r;
    assign bus.done1     = done1_r;
    assign bus.ocupado   = ocupado_r;
    assign bus.ctrl_ula  = ctrl_r;
    assign bus.num2      = num2_r;
    assign bus.num1      = num1_r;
    assign bus.resultado = resultado_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_arbitro_ula.sv
// -----------------------------------------------------------------------------
// tb_arbitro_ula
// Directed bench for arbitro_ula. Plays both requesters and the combinational
// ALU. Expected results are queued when a request is raised and compared when
// the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_arbitro_ula;

    localparam int W = 8;

    logic clock;
    logic resetn;

    arbitro_ula_if #(.LARGURA(W)) bus ();

    arbitro_ula #(.LARGURA(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Combinational ALU: num2 +/- num1, zero flag only meaningful on subtract.
    assign bus.resultado_ula = bus.ctrl_ula ? (bus.num2 - bus.num1) : (bus.num2 + bus.num1);
    assign bus.zero_ula      = bus.ctrl_ula & (bus.num2 == bus.num1);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         id;
        logic [W-1:0] res;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   gnt_order[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done0_cnt = 0;
    int   done1_cnt = 0;
    logic g0_q = 1'b0;
    logic g1_q = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input bit id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.res = op ? (a - b) : (a + b);
        e.z   = op && (a == b);
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit k);
        int n;
        n = 0;
        while (!(k ? bus.done1 : bus.done0) && n < 20) begin
            tick();
            n++;
        end
        chk(k ? "wait_done1" : "wait_done0", k ? bus.done1 : bus.done0, 1);
    endtask

    // Scoreboard side: every done pulse pops one expectation.
    always @(negedge clock) begin
        if (resetn && (bus.done0 || bus.done1)) begin
            exp_t e;
            chk("done_exclusive", {31'd0, bus.done0 & bus.done1}, 0);
            if (bus.done0) done0_cnt++;
            if (bus.done1) done1_cnt++;
            chk("sb_nonempty_on_done", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_id", {31'd0, bus.done1}, {31'd0, e.id});
                chk("resultado", {24'd0, bus.resultado}, {24'd0, e.res});
                chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
            end
        end
    end

    // Grant order log (rising edges of gnt).
    always @(negedge clock) begin
        if (bus.gnt0 && !g0_q) gnt_order.push_back(0);
        if (bus.gnt1 && !g1_q) gnt_order.push_back(1);
        g0_q = bus.gnt0;
        g1_q = bus.gnt1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int t0, t1;
        int issued0, issued1, ndone;
        bit rr0, rr1;

        resetn   = 1'b0;
        bus.req0 = 1'b0; bus.op0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.op1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        tick(); tick();

        // ---- reset state
        chk("rst_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk("rst_done",    {30'd0, bus.done1, bus.done0}, 0);
        chk("rst_ocupado", {31'd0, bus.ocupado}, 0);
        chk("rst_alu_in",  {15'd0, bus.ctrl_ula, bus.num2, bus.num1}, 0);
        chk("rst_res",     {23'd0, bus.zero, bus.resultado}, 0);
        resetn = 1'b1;
        tick();

        // ---- single add with exact latency
        bus.op0 = 1'b0; bus.a0 = 8'h05; bus.b0 = 8'h03; bus.req0 = 1'b1;
        push(0, 0, 8'h05, 8'h03);
        tick(); // E0
        chk("add_gnt0",    {30'd0, bus.gnt1, bus.gnt0}, 1);
        chk("add_ocupado", {31'd0, bus.ocupado}, 1);
        chk("add_alu_in",  {15'd0, bus.ctrl_ula, bus.num2, bus.num1}, {15'd0, 1'b0, 8'h05, 8'h03});
        tick(); // E1
        chk("add_done_e1", {31'd0, bus.done0}, 0);
        tick(); // E2
        chk("add_done_e2", {31'd0, bus.done0}, 1);
        bus.req0 = 1'b0;
        tick(); // E3
        chk("add_done_e3", {31'd0, bus.done0}, 0);
        chk("add_idle",    {31'd0, bus.ocupado}, 0);

        // ---- subtract: equal operands, then wrap-around
        bus.op1 = 1'b1; bus.a1 = 8'h2A; bus.b1 = 8'h2A; bus.req1 = 1'b1;
        push(1, 1, 8'h2A, 8'h2A);
        wait_done(1);
        bus.req1 = 1'b0;
        tick();
        bus.a1 = 8'h00; bus.b1 = 8'h01; bus.req1 = 1'b1;
        push(1, 1, 8'h00, 8'h01);
        wait_done(1);
        bus.req1 = 1'b0;
        tick();

        // ---- held request: exactly one service until req drops
        snap = done0_cnt;
        bus.op0 = 1'b0; bus.a0 = 8'hF0; bus.b0 = 8'h20; bus.req0 = 1'b1;
        push(0, 0, 8'hF0, 8'h20);
        wait_done(0);
        repeat (5) tick();
        chk("held_one_done", done0_cnt - snap, 1);
        chk("held_no_regrant", {31'd0, bus.gnt0}, 0);
        bus.req0 = 1'b0;
        tick();
        bus.op0 = 1'b1; bus.a0 = 8'h33; bus.b0 = 8'h11; bus.req0 = 1'b1;
        push(0, 1, 8'h33, 8'h11);
        wait_done(0);
        bus.req0 = 1'b0;
        tick();
        chk("held_second_done", done0_cnt - snap, 2);

        // ---- reset during EXECUTA (last served was 0, so ultimo must reset)
        snap = done0_cnt;
        bus.op0 = 1'b1; bus.a0 = 8'h77; bus.b0 = 8'h07; bus.req0 = 1'b1;
        tick(); // granted
        chk("mid_gnt0", {31'd0, bus.gnt0}, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_gnt",   {29'd0, bus.ocupado, bus.gnt1, bus.gnt0}, 0);
        chk("mid_rst_alu",   {15'd0, bus.ctrl_ula, bus.num2, bus.num1}, 0);
        chk("mid_rst_res",   {23'd0, bus.zero, bus.resultado}, 0);
        bus.req0 = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        repeat (3) tick();
        chk("mid_no_done", done0_cnt - snap, 0);

        // ---- tie after reset: 0 first, then 1, 3 cycles apart
        gnt_order.delete();
        bus.op0 = 1'b0; bus.a0 = 8'h01; bus.b0 = 8'h02;
        bus.op1 = 1'b1; bus.a1 = 8'h09; bus.b1 = 8'h04;
        push(0, 0, 8'h01, 8'h02);
        push(1, 1, 8'h09, 8'h04);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        t0 = -1; t1 = -1;
        for (int i = 0; i < 20 && (t0 < 0 || t1 < 0); i++) begin
            tick();
            if (bus.done0 && t0 < 0) begin t0 = cyc; bus.req0 = 1'b0; end
            if (bus.done1 && t1 < 0) begin t1 = cyc; bus.req1 = 1'b0; end
        end
        chk("tie_both_done", {30'd0, t1 >= 0, t0 >= 0}, 3);
        chk("tie_spacing",   t1 - t0, 3);
        chk("tie_order_len", gnt_order.size(), 2);
        if (gnt_order.size() == 2) begin
            chk("tie_first",  gnt_order[0], 0);
            chk("tie_second", gnt_order[1], 1);
        end
        tick();

        // ---- continuous contention: strict alternation 0,1,0,1
        gnt_order.delete();
        bus.op0 = 1'b0; bus.a0 = 8'h80; bus.b0 = 8'h80;
        bus.op1 = 1'b1; bus.a1 = 8'h10; bus.b1 = 8'h01;
        push(0, 0, 8'h80, 8'h80);
        push(1, 1, 8'h10, 8'h01);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        issued0 = 1; issued1 = 1; ndone = 0; rr0 = 0; rr1 = 0;
        for (int i = 0; i < 60 && ndone < 4; i++) begin
            tick();
            if (bus.done0) begin
                ndone++; bus.req0 = 1'b0; rr0 = (issued0 < 2);
            end else if (rr0) begin
                rr0 = 0; issued0++;
                bus.op0 = 1'b1; bus.a0 = 8'h10; bus.b0 = 8'h20;
                push(0, 1, 8'h10, 8'h20);
                bus.req0 = 1'b1;
            end
            if (bus.done1) begin
                ndone++; bus.req1 = 1'b0; rr1 = (issued1 < 2);
            end else if (rr1) begin
                rr1 = 0; issued1++;
                bus.op1 = 1'b0; bus.a1 = 8'hFF; bus.b1 = 8'h01;
                push(1, 0, 8'hFF, 8'h01);
                bus.req1 = 1'b1;
            end
        end
        chk("alt_dones", ndone, 4);
        chk("alt_len", gnt_order.size(), 4);
        if (gnt_order.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("alt_order", gnt_order[i], i % 2);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) tick();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_ula.md
# arbitro_ula

Round-robin arbiter and sequencer that shares the single 8-bit add/subtract ALU between two requesters (e.g. the branch-compare path and the address-increment path). Each requester presents an operation and two operands under a req/done handshake; the block latches the winning request, drives the ALU for one cycle, registers the result and zero flag, and returns them with a one-cycle done pulse. The ALU itself stays purely combinational outside this block.

## Interface
- LARGURA, 8, operand/result width; must match the ALU width.
- clock  in  1  rising-edge system clock
- resetn  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  request from requester 0 / 1; level, held until done
- op0, op1  in  1 each  operation: 0 = add, 1 = subtract
- a0, a1, b0, b1  in  LARGURA each  operands; result = a + b or a − b
- gnt0, gnt1  out  1 each  grant; high while that requester owns the ALU
- done0, done1  out  1 each  one-cycle pulse: result for that requester valid
- resultado  out  LARGURA  registered result, shared by both requesters
- zero  out  1  registered ALU zero flag (meaningful for subtract only)
- ctrl_ula  out  1  to ALU control input (0 add, 1 subtract)
- num2, num1  out  LARGURA each  to ALU operands; ALU computes num2 ± num1
- resultado_ula, zero_ula  in  LARGURA / 1  from ALU outputs
- ocupado  out  1  high in any state other than OCIOSO

## Operation
- States: OCIOSO, EXECUTA, RESPONDE.
- OCIOSO: requester k is eligible when reqk = 1 and armadok = 1. If none eligible, stay. If one, grant it. If both, grant the one not served last (pointer ultimo); ultimo resets to 1, so requester 0 wins the first tie.
- On grant (OCIOSO → EXECUTA): latch opk → ctrl_ula, ak → num2, bk → num1; set gntk; update ultimo = k.
- EXECUTA → RESPONDE unconditionally: capture resultado_ula → resultado and zero_ula → zero at the end of the cycle.
- RESPONDE → OCIOSO unconditionally: donek = 1 for exactly this cycle; gntk stays 1; clear armadok.
- armadok: set to 1 whenever reqk = 0; cleared in RESPONDE for the served requester. A requester that keeps req high past its done is ignored until it drops req for at least one cycle (no duplicate service).
- Requester dropping req while not granted: withdrawn, no effect. Dropping req after grant: operation still completes and done still pulses (operands already latched).
- Arithmetic: modulo 2^LARGURA, no carry/overflow output; zero is whatever the ALU reports (ALU forces 0 on add).
- resultado, zero hold their last value until the next capture.

## Timing
- Reset (asynchronous, immediate): state OCIOSO, gnt0 = gnt1 = 0, done0 = done1 = 0, resultado = 0, zero = 0, ctrl_ula = 0, num1 = num2 = 0, ocupado = 0, ultimo = 1, armado0 = armado1 = 1.
- Latency: req sampled at edge E0 → gnt high after E0 → done high after E2, low after E3. One request per 3 cycles at most; back-to-back alternate grants every 3 cycles.
- ctrl_ula/num1/num2 stable from E0 to next grant; ALU path must settle within one cycle.
- Reset mid-operation: transaction aborted, no done pulse, requester must re-request.
- Starvation bound: an eligible requester is granted within at most one other transaction (≤ 3 cycles wait after OCIOSO returns).

## Test plan
- Single add: req0, op0 = 0, a0 = 8'h05, b0 = 8'h03 → gnt0 next cycle, done0 two cycles after grant edge with resultado = 8'h08, zero = 0.
- Subtract equal: req1, op1 = 1, a1 = b1 = 8'h2A → done1 with resultado = 8'h00, zero = 1; a1 = 8'h00, b1 = 8'h01 → resultado = 8'hFF, zero = 0.
- Tie after reset: req0 and req1 raised together and held (dropped after own done) → order 0, then 1; done pulses 3 cycles apart.
- Held req: req0 kept high across done0 for 5 cycles → exactly one done0; after one low cycle and re-raise → second service.
- Alternation under continuous contention: both re-requesting immediately after done → grants strictly alternate 0,1,0,1 over 12 cycles.
- Reset during EXECUTA: assert resetn = 0 → all outputs at reset values immediately, no done pulse, ultimo = 1 after release.
